prog_loader: RTL and testbench

- Byte-stream program loader: the write-side counterpart of the CPU's instruction fetch path.
- Accepts a framed byte stream (header, instruction words, checksum) over a valid/ready handshake.
- Packs byte pairs big-endian into 16-bit instruction words and writes them into instruction memory at consecutive addresses from 0.
- Asserts cpu_hold for the whole load so the CPU does not fetch a half-written program. Checks the checksum and the opcode field of every word.

---
 rtl/prog_loader_pkg.sv | 61 ++++++
 rtl/prog_loader_if.sv | 42 ++++
 rtl/prog_loader.sv | 168 ++++++++++++++++
 tb/tb_prog_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// prog_loader_pkg
//
// Shared definitions for the program loader and the CPU instruction path:
//   - instruction word field positions ({opcode, dest, src})
//   - opcode constants
//   - loader FSM state encoding
//   - small helpers for extracting and classifying instruction fields
// -----------------------------------------------------------------------------
package prog_loader_pkg;

    // Instruction word geometry
    localparam int WORD_W   = 16;
    localparam int BYTE_W   = 8;

    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int DEST_MSB = 11;
    localparam int DEST_LSB = 6;
    localparam int SRC_MSB  = 5;
    localparam int SRC_LSB  = 0;

    localparam int OPC_W    = OPC_MSB - OPC_LSB + 1;

    // Opcodes understood by the CPU; anything above OP_HALT is undefined
    localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OP_MOV  = 4'h1;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'h2;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'h3;
    localparam logic [OPC_W-1:0] OP_AND  = 4'h4;
    localparam logic [OPC_W-1:0] OP_OR   = 4'h5;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'h6;
    localparam logic [OPC_W-1:0] OP_HALT = 4'h7;

    // Loader FSM states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_WRITE = 3'd4,
        ST_CSUM  = 3'd5,
        ST_DONE  = 3'd6
    } ld_state_e;

    // Error code bit positions
    localparam int ERR_CSUM_BIT = 0;
    localparam int ERR_OPC_BIT  = 1;

    // Opcode field of an instruction word
    function automatic logic [OPC_W-1:0] opcode_of(input logic [WORD_W-1:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

    // True when the word carries an opcode above the legal ceiling
    function automatic logic opcode_illegal(input logic [WORD_W-1:0] word,
                                            input logic [OPC_W-1:0]  opc_max);
        return (opcode_of(word) > opc_max);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// -----------------------------------------------------------------------------
// prog_loader_if
//
// Bundles the loader's two buses:
//   - byte stream in : rx_data, rx_valid (source -> loader), rx_ready (loader -> source)
//   - memory write   : mem_we, mem_addr, mem_wdata (loader -> instruction memory)
//
// Modports:
//   master : the system side (byte source / instruction memory)
//   slave  : the loader
// -----------------------------------------------------------------------------
interface prog_loader_if #(
    parameter int unsigned ADDR_W = 8
);

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

endinterface

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Byte-stream program loader. Receives a frame
//     N, {hi,lo} x N, checksum
// over a valid/ready byte stream, packs each byte pair big-endian into a 16-bit
// instruction word and writes the words to instruction memory from address 0.
// The checksum is the XOR of the header and every payload byte. cpu_hold keeps
// the CPU parked for the whole load.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   start         one-cycle pulse starting a load (ignored while busy)
//   bus           prog_loader_if.slave: rx_data/rx_valid/rx_ready byte stream,
//                 mem_we/mem_addr/mem_wdata instruction memory write port
//   cpu_hold      high while a load is in progress
//   busy          high in every state except IDLE
//   done          one-cycle pulse at the end of a load
//   error_code    bit0 checksum mismatch, bit1 illegal opcode; sticky until
//                 the next accepted start
//   words_loaded  words written in the current/last load
// -----------------------------------------------------------------------------
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned      ADDR_W     = 8,
    parameter logic [OPC_W-1:0] OPCODE_MAX = 4'h7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    prog_loader_if.slave      bus,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [1:0]        error_code,
    output logic [ADDR_W-1:0] words_loaded
);

    ld_state_e          state;
    logic [BYTE_W-1:0]  csum;
    logic [BYTE_W-1:0]  hi_byte;
    logic [BYTE_W-1:0]  word_total;
    // Full 8-bit word count used for termination, so that a narrow ADDR_W
    // (where words_loaded/mem_addr wrap) still ends the load after N words.
    logic [BYTE_W-1:0]  word_cnt;
    logic [BYTE_W-1:0]  word_cnt_nxt;
    logic               fire;

    assign fire         = bus.rx_valid && bus.rx_ready;
    assign word_cnt_nxt = word_cnt + 8'd1;

    // All outputs are registered. rx_ready, busy and cpu_hold are set on the
    // transition into the state they belong to, so they line up exactly with
    // the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            bus.rx_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            cpu_hold      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error_code    <= 2'b00;
            words_loaded  <= '0;
            csum          <= '0;
            hi_byte       <= '0;
            word_total    <= '0;
            word_cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_HDR;
                        bus.rx_ready <= 1'b1;
                        cpu_hold     <= 1'b1;
                        busy         <= 1'b1;
                        error_code   <= 2'b00;
                        words_loaded <= '0;
                        word_cnt     <= '0;
                        csum         <= '0;
                    end
                end

                ST_HDR: begin
                    if (fire) begin
                        word_total <= bus.rx_data;
                        csum       <= bus.rx_data;
                        // An empty program goes straight to the checksum byte
                        if (bus.rx_data == 8'd0) begin
                            state <= ST_CSUM;
                        end else begin
                            state <= ST_HI;
                        end
                    end
                end

                ST_HI: begin
                    if (fire) begin
                        hi_byte <= bus.rx_data;
                        csum    <= csum ^ bus.rx_data;
                        state   <= ST_LO;
                    end
                end

                ST_LO: begin
                    if (fire) begin
                        bus.mem_wdata <= {hi_byte, bus.rx_data};
                        csum          <= csum ^ bus.rx_data;
                        // Launch the write: mem_we is high for the WRITE cycle only
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= words_loaded;
                        bus.rx_ready  <= 1'b0;
                        state         <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    bus.mem_we   <= 1'b0;
                    bus.rx_ready <= 1'b1;
                    // Illegal words are still written; only the flag is raised
                    if (opcode_illegal(bus.mem_wdata, OPCODE_MAX)) begin
                        error_code[ERR_OPC_BIT] <= 1'b1;
                    end
                    word_cnt     <= word_cnt_nxt;
                    words_loaded <= words_loaded + ADDR_W'(1);
                    if (word_cnt_nxt == word_total) begin
                        state <= ST_CSUM;
                    end else begin
                        state <= ST_HI;
                    end
                end

                ST_CSUM: begin
                    if (fire) begin
                        if (bus.rx_data != csum) begin
                            error_code[ERR_CSUM_BIT] <= 1'b1;
                        end
                        bus.rx_ready <= 1'b0;
                        done         <= 1'b1;
                        state        <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // cpu_hold and busy stay up through the done cycle
                    done     <= 1'b0;
                    cpu_hold <= 1'b0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end

                default: begin
                    state        <= ST_IDLE;
                    bus.rx_ready <= 1'b0;
                    bus.mem_we   <= 1'b0;
                    cpu_hold     <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//
// Directed bench for prog_loader: drives framed byte streams through the
// interface, records memory writes / done pulses / cpu_hold cycles at the
// falling edge and compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_prog_loader;

    logic       clk;
    logic       reset;
    logic       start;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic [1:0] error_code;
    logic [7:0] words_loaded;

    int total = 0;
    int bad   = 0;

    prog_loader_if #(.ADDR_W(8)) bus ();

    prog_loader #(
        .ADDR_W     (8),
        .OPCODE_MAX (4'h7)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error_code   (error_code),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- monitor ----------------
    logic [23:0] wr_q[$];
    int          done_cnt    = 0;
    int          hold_cnt    = 0;
    logic        hold_at_done = 1'b0;

    always @(negedge clk) begin
        if (bus.mem_we) wr_q.push_back({bus.mem_addr, bus.mem_wdata});
        if (done) begin
            done_cnt     = done_cnt + 1;
            hold_at_done = cpu_hold;
        end
        if (cpu_hold) hold_cnt = hold_cnt + 1;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wr_at(input int i);
        if (i < wr_q.size()) return 32'(wr_q[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("rdy_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] s[$], input int gap);
        foreach (s[i]) begin
            send_byte(s[i]);
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_done(input int base);
        int n = 0;
        while (done_cnt == base && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("done_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] s[$];
    int wb, db, hb;

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);

        chk("rst_hold",  32'(cpu_hold),     32'd0);
        chk("rst_busy",  32'(busy),         32'd0);
        chk("rst_done",  32'(done),         32'd0);
        chk("rst_rdy",   32'(bus.rx_ready), 32'd0);
        chk("rst_we",    32'(bus.mem_we),   32'd0);
        chk("rst_err",   32'(error_code),   32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);

        reset = 1'b0;
        @(negedge clk);

        // Normal load: 0x1041@0, 0x2082@1, checksum F1
        wb = wr_q.size(); db = done_cnt; hb = hold_cnt;
        do_start();
        chk("nrm_hold_on", 32'(cpu_hold), 32'd1);
        chk("nrm_busy_on", 32'(busy),     32'd1);
        s = {8'h02, 8'h10, 8'h41, 8'h20, 8'h82, 8'hF1};
        send_stream(s, 0);
        wait_done(db);
        chk("nrm_nwr",   32'(wr_q.size() - wb), 32'd2);
        chk("nrm_w0",    wr_at(wb),             32'h0000_1041);
        chk("nrm_w1",    wr_at(wb + 1),         32'h0001_2082);
        chk("nrm_done",  32'(done_cnt - db),    32'd1);
        chk("nrm_err",   32'(error_code),       32'd0);
        chk("nrm_words", 32'(words_loaded),     32'd2);
        chk("nrm_hcyc",  32'(hold_cnt - hb),    32'd9);
        chk("nrm_hdone", 32'(hold_at_done),     32'd1);
        chk("nrm_hold_off", 32'(cpu_hold),      32'd0);
        chk("nrm_busy_off", 32'(busy),          32'd0);

        // Empty program
        wb = wr_q.size(); db = done_cnt; hb = hold_cnt;
        do_start();
        s = {8'h00, 8'h00};
        send_stream(s, 0);
        wait_done(db);
        chk("emp_nwr",   32'(wr_q.size() - wb), 32'd0);
        chk("emp_done",  32'(done_cnt - db),    32'd1);
        chk("emp_err",   32'(error_code),       32'd0);
        chk("emp_words", 32'(words_loaded),     32'd0);
        chk("emp_hcyc",  32'(hold_cnt - hb),    32'd3);

        // Bad checksum with stalls between bytes
        wb = wr_q.size(); db = done_cnt;
        do_start();
        s = {8'h02, 8'h10, 8'h41, 8'h20, 8'h82, 8'hF0};
        send_stream(s, 2);
        wait_done(db);
        chk("bcs_nwr",   32'(wr_q.size() - wb), 32'd2);
        chk("bcs_w0",    wr_at(wb),             32'h0000_1041);
        chk("bcs_w1",    wr_at(wb + 1),         32'h0001_2082);
        chk("bcs_err",   32'(error_code),       32'd1);
        chk("bcs_words", 32'(words_loaded),     32'd2);

        // Illegal opcode; error from previous load must clear on start
        wb = wr_q.size(); db = done_cnt; hb = hold_cnt;
        do_start();
        chk("ill_errclr", 32'(error_code), 32'd0);
        s = {8'h01, 8'hF0, 8'h00, 8'hF1};
        send_stream(s, 0);
        wait_done(db);
        chk("ill_nwr",   32'(wr_q.size() - wb), 32'd1);
        chk("ill_w0",    wr_at(wb),             32'h0000_F000);
        chk("ill_err",   32'(error_code),       32'd2);
        chk("ill_words", 32'(words_loaded),     32'd1);
        chk("ill_hcyc",  32'(hold_cnt - hb),    32'd6);

        // Reset in HI of the second word
        do_start();
        s = {8'h02, 8'h10, 8'h41};
        send_stream(s, 0);
        @(negedge clk);
        chk("mid_words_pre", 32'(words_loaded), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_hold",  32'(cpu_hold),      32'd0);
        chk("mid_busy",  32'(busy),          32'd0);
        chk("mid_rdy",   32'(bus.rx_ready),  32'd0);
        chk("mid_addr",  32'(bus.mem_addr),  32'd0);
        chk("mid_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("mid_words", 32'(words_loaded),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Start coincident with reset is ignored
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", 32'(busy), 32'd0);

        // Reload after reset; start pulsed mid-load must be ignored
        wb = wr_q.size(); db = done_cnt; hb = hold_cnt;
        do_start();
        s = {8'h02, 8'h10};
        send_stream(s, 0);
        start = 1'b1;
        s = {8'h41, 8'h20};
        send_stream(s, 0);
        start = 1'b0;
        s = {8'h82, 8'hF1};
        send_stream(s, 0);
        wait_done(db);
        chk("rld_nwr",   32'(wr_q.size() - wb), 32'd2);
        chk("rld_w0",    wr_at(wb),             32'h0000_1041);
        chk("rld_w1",    wr_at(wb + 1),         32'h0001_2082);
        chk("rld_err",   32'(error_code),       32'd0);
        chk("rld_words", 32'(words_loaded),     32'd2);
        chk("rld_hcyc",  32'(hold_cnt - hb),    32'd9);
        chk("rld_done",  32'(done_cnt - db),    32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
